// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared types and constants for the MEM-stage access unit:
//                FSM state encoding, access-size encodings, RAM depth and a
//                helper that classifies misaligned accesses.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

    // Number of 32-bit words in the data RAM (1 KB byte-address window).
    localparam int MEM_DEPTH = 256;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);

    // Access-size encodings carried on MEM_Datatype.
    localparam logic [1:0] DT_WORD  = 2'b00;
    localparam logic [1:0] DT_HALF  = 2'b01;
    localparam logic [1:0] DT_BYTE  = 2'b10;
    localparam logic [1:0] DT_UBYTE = 2'b11;

    // Load sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } mau_state_t;

    // Word accesses need a 4-byte aligned address, halves a 2-byte aligned
    // address; bytes can sit anywhere.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] dtype);
        logic mis;
        mis = 1'b0;
        if (dtype == DT_WORD) begin
            mis = (addr_lo != 2'b00);
        end else if (dtype == DT_HALF) begin
            mis = addr_lo[0];
        end
        return mis;
    endfunction

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram
//  Description : Single-port word RAM with per-byte write enables and a
//                registered (synchronous) read port. Contents are never
//                cleared by reset.
//  Revision    : 1.0  initial release
// ============================================================================
module data_ram
    import mem_access_unit_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane writes; only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l]) begin
                r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
    end

    // Registered read; output holds between read strobes.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : data_ram
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM pipeline stage: branch resolution, sub-word store lane
//                steering, a three-state load sequencer around a synchronous
//                RAM, load lane select / extension and misalignment flagging.
//                Load issued in cycle N returns MEM_ReadData in cycle N+2.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Datatype,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_Data2,
    input  logic        MEM_Branch,
    input  logic        MEM_Zero,
    output logic [31:0] MEM_ReadData,
    output logic        MEM_Valid,
    output logic        MEM_Stall,
    output logic        PCSrc,
    output logic        MisalignErr
);

    mau_state_t  r_state;
    mau_state_t  w_next_state;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_dtype;
    logic [31:0] r_read_data;
    logic        r_misalign;

    logic        w_misaligned;
    logic        w_start_rd;
    logic        w_do_wr;
    logic        w_stall;
    logic        w_valid;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused;

    // Upper address bits fall outside the 1 KB window and wrap.
    assign w_unused = ^MEM_ALUResult[31:10];

    assign PCSrc        = MEM_Branch & MEM_Zero;
    assign w_misaligned = is_misaligned(MEM_ALUResult[1:0], MEM_Datatype);

    // Next-state and handshake decode; requests are only accepted in IDLE
    // and never while reset is asserted. A read always wins over a write.
    always_comb begin
        w_next_state = r_state;
        w_start_rd   = 1'b0;
        w_do_wr      = 1'b0;
        w_stall      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Clr && MEM_MemRead) begin
                    if (!w_misaligned) begin
                        w_start_rd   = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = RD_WAIT;
                    end
                end else if (Clr && MEM_MemWrite && !w_misaligned) begin
                    w_do_wr = 1'b1;
                end
            end
            RD_WAIT: begin
                w_stall      = 1'b1;
                w_next_state = RD_DONE;
            end
            RD_DONE: begin
                w_valid      = Clr;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Store lane steering: data replicated across lanes, enables pick lanes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = MEM_Data2;
        case (MEM_Datatype)
            DT_WORD: begin
                w_be    = 4'b1111;
                w_wdata = MEM_Data2;
            end
            DT_HALF: begin
                w_be    = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{MEM_Data2[15:0]}};
            end
            default: begin
                w_be    = 4'b0001 << MEM_ALUResult[1:0];
                w_wdata = {4{MEM_Data2[7:0]}};
            end
        endcase
        if (!w_do_wr) begin
            w_be = 4'b0000;
        end
    end

    data_ram #(
        .DEPTH (MEM_DEPTH)
    ) u_data_ram (
        .clk     (Clk),
        .i_re    (w_start_rd),
        .i_addr  (MEM_ALUResult[9:2]),
        .i_we    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Load lane select and sign/zero extension from the captured offset/size.
    always_comb begin
        w_byte = w_ram_rdata[8*r_addr_lo +: 8];
        w_half = r_addr_lo[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
        case (r_dtype)
            DT_WORD:  w_ext = w_ram_rdata;
            DT_HALF:  w_ext = {{16{w_half[15]}}, w_half};
            DT_BYTE:  w_ext = {{24{w_byte[7]}}, w_byte};
            default:  w_ext = {24'h0, w_byte};
        endcase
    end

    // Capture request attributes, load result and the misalignment pulse.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            r_addr_lo   <= 2'b00;
            r_dtype     <= DT_WORD;
            r_read_data <= 32'h0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_start_rd) begin
                r_addr_lo <= MEM_ALUResult[1:0];
                r_dtype   <= MEM_Datatype;
            end
            if (r_state == RD_WAIT) begin
                r_read_data <= w_ext;
            end
            r_misalign <= (r_state == IDLE) && (MEM_MemRead || MEM_MemWrite)
                          && w_misaligned;
        end
    end

    assign MEM_ReadData = r_read_data;
    assign MEM_Valid    = w_valid;
    assign MEM_Stall    = w_stall;
    assign MisalignErr  = r_misalign;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a byte-level
//                reference memory and directed plus random accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [1:0] W  = 2'b00;
    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] SB = 2'b10;
    localparam logic [1:0] UB = 2'b11;

    logic        Clk;
    logic        Clr;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [1:0]  MEM_Datatype;
    logic [31:0] MEM_ALUResult;
    logic [31:0] MEM_Data2;
    logic        MEM_Branch;
    logic        MEM_Zero;
    logic [31:0] MEM_ReadData;
    logic        MEM_Valid;
    logic        MEM_Stall;
    logic        PCSrc;
    logic        MisalignErr;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [256];
    logic [31:0] exp_hold;
    logic [31:0] got;

    mem_access_unit dut (
        .Clk           (Clk),
        .Clr           (Clr),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_MemWrite  (MEM_MemWrite),
        .MEM_Datatype  (MEM_Datatype),
        .MEM_ALUResult (MEM_ALUResult),
        .MEM_Data2     (MEM_Data2),
        .MEM_Branch    (MEM_Branch),
        .MEM_Zero      (MEM_Zero),
        .MEM_ReadData  (MEM_ReadData),
        .MEM_Valid     (MEM_Valid),
        .MEM_Stall     (MEM_Stall),
        .PCSrc         (PCSrc),
        .MisalignErr   (MisalignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] dt);
        if (dt == W) return (a % 4) != 0;
        if (dt == H) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] dt);
        logic [15:0] h;
        logic [7:0]  b;
        h = 16'(word >> (16 * ((a / 2) % 2)));
        b = 8'(word >> (8 * (a % 4)));
        case (dt)
            W:       return word;
            H:       return {{16{h[15]}}, h};
            SB:      return {{24{b[7]}}, b};
            default: return {24'h0, b};
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] dt, input logic [31:0] d);
        int idx;
        int size;
        int first;
        idx   = int'((a / 4) % 256);
        size  = (dt == W) ? 4 : (dt == H) ? 2 : 1;
        first = int'(a % 4);
        for (int k = 0; k < size; k++) begin
            model_mem[idx][8*(first+k) +: 8] = 8'(d >> (8*k));
        end
    endtask

    task automatic set_idle();
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] dt, input logic [31:0] d);
        logic mis;
        mis = ref_mis(a, dt);
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b1; MEM_Datatype = dt;
        MEM_ALUResult = a; MEM_Data2 = d;
        MEM_Branch = 1'($urandom); MEM_Zero = 1'($urandom);
        @(negedge Clk);
        chk("st_pcsrc", PCSrc, MEM_Branch & MEM_Zero);
        chk("st_stall", MEM_Stall, 1'b0);
        tick();
        set_idle();
        if (!mis) ref_store(a, dt, d);
        @(negedge Clk);
        chk("st_misalign", MisalignErr, mis);
        chk("st_valid", MEM_Valid, 1'b0);
        tick();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] dt, input logic wr,
                           output logic [31:0] obs);
        logic mis;
        logic [31:0] exp;
        mis = ref_mis(a, dt);
        exp = ref_load(model_mem[(a / 4) % 256], a, dt);
        obs = MEM_ReadData;
        MEM_MemRead = 1'b1; MEM_MemWrite = wr; MEM_Datatype = dt;
        MEM_ALUResult = a; MEM_Data2 = $urandom;
        MEM_Branch = 1'($urandom); MEM_Zero = 1'($urandom);
        @(negedge Clk);
        chk("ld_pcsrc", PCSrc, MEM_Branch & MEM_Zero);
        chk("ld_req_stall", MEM_Stall, !mis);
        chk("ld_req_valid", MEM_Valid, 1'b0);
        tick();
        set_idle();
        @(negedge Clk);
        chk("ld_misalign", MisalignErr, mis);
        chk("ld_hold", MEM_ReadData, exp_hold);
        if (mis) begin
            chk("ld_mis_stall", MEM_Stall, 1'b0);
            chk("ld_mis_valid", MEM_Valid, 1'b0);
        end else begin
            chk("ld_wait_stall", MEM_Stall, 1'b1);
            chk("ld_wait_valid", MEM_Valid, 1'b0);
            tick();
            @(negedge Clk);
            chk("ld_done_valid", MEM_Valid, 1'b1);
            chk("ld_done_stall", MEM_Stall, 1'b0);
            chk("ld_data", MEM_ReadData, exp);
            obs = MEM_ReadData;
            exp_hold = exp;
            tick();
            @(negedge Clk);
            chk("ld_after_valid", MEM_Valid, 1'b0);
            chk("ld_after_hold", MEM_ReadData, exp_hold);
        end
        tick();
    endtask

    initial begin
        Clr = 1'b0;
        set_idle();
        MEM_Datatype = W; MEM_ALUResult = '0; MEM_Data2 = '0;
        MEM_Branch = 1'b0; MEM_Zero = 1'b0;
        exp_hold = 32'h0;

        // Reset state
        repeat (3) tick();
        @(negedge Clk);
        chk("rst_stall", MEM_Stall, 1'b0);
        chk("rst_valid", MEM_Valid, 1'b0);
        chk("rst_data", MEM_ReadData, 32'h0);
        chk("rst_misalign", MisalignErr, 1'b0);
        chk("rst_pcsrc", PCSrc, 1'b0);
        tick();
        Clr = 1'b1;
        tick();

        // Fill every word so the model and RAM agree everywhere.
        for (int i = 0; i < 256; i++) do_store(32'(i * 4), W, $urandom);

        // Word store then load
        do_store(32'h10, W, 32'hDEADBEEF);
        do_load(32'h10, W, 1'b0, got);
        chk("word_0x10", got, 32'hDEADBEEF);

        // Sub-word loads
        do_store(32'h20, W, 32'h80FF7F01);
        do_load(32'h21, SB, 1'b0, got);  chk("sb_0x21", got, 32'h0000007F);
        do_load(32'h23, SB, 1'b0, got);  chk("sb_0x23", got, 32'hFFFFFF80);
        do_load(32'h22, UB, 1'b0, got);  chk("ub_0x22", got, 32'h000000FF);
        do_load(32'h22, H,  1'b0, got);  chk("sh_0x22", got, 32'hFFFF80FF);
        do_load(32'h20, H,  1'b0, got);  chk("sh_0x20", got, 32'h00007F01);

        // Byte store into an existing word
        do_store(32'h30, W, 32'h11223344);
        do_store(32'h31, SB, 32'h000000AA);
        do_load(32'h30, W, 1'b0, got);   chk("byte_st", got, 32'h1122AA44);
        do_store(32'h32, H, 32'h0000BEEF);
        do_load(32'h30, W, 1'b0, got);   chk("half_st", got, 32'hBEEFAA44);

        // Misaligned accesses and address wrap
        do_load(32'h06, W, 1'b0, got);
        do_store(32'h13, H, 32'h00005555);
        do_load(32'h10, W, 1'b0, got);   chk("mis_st_nowrite", got, 32'hDEADBEEF);
        do_store(32'h400, W, 32'h0BADF00D);
        do_load(32'h0, W, 1'b0, got);    chk("wrap_0x400", got, 32'h0BADF00D);

        // Read and write together: read wins, memory unchanged
        do_store(32'h40, W, 32'hCAFEF00D);
        do_load(32'h40, W, 1'b1, got);   chk("prio_rd", got, 32'hCAFEF00D);
        do_load(32'h40, W, 1'b0, got);   chk("prio_nowrite", got, 32'hCAFEF00D);

        // Reset in RD_WAIT aborts the load
        MEM_MemRead = 1'b1; MEM_Datatype = W; MEM_ALUResult = 32'h10;
        tick();
        set_idle();
        Clr = 1'b0;
        tick();
        Clr = 1'b1;
        @(negedge Clk);
        chk("abort_valid", MEM_Valid, 1'b0);
        chk("abort_stall", MEM_Stall, 1'b0);
        chk("abort_data", MEM_ReadData, 32'h0);
        exp_hold = 32'h0;
        tick();
        @(negedge Clk);
        chk("abort_valid2", MEM_Valid, 1'b0);
        tick();
        do_load(32'h10, W, 1'b0, got);   chk("mem_kept", got, 32'hDEADBEEF);

        // Branch resolution
        MEM_Branch = 1'b1; MEM_Zero = 1'b1;
        #1 chk("pcsrc_11", PCSrc, 1'b1);
        MEM_Zero = 1'b0;
        #1 chk("pcsrc_10", PCSrc, 1'b0);
        tick();

        // Random mix of accesses
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [1:0]  dt;
            int          kind;
            a    = $urandom;
            dt   = 2'($urandom);
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (dt == W) a[1:0] = 2'b00;
                else if (dt == H) a[0] = 1'b0;
            end
            case (kind)
                0, 1:    do_load(a, dt, 1'b0, got);
                2:       do_store(a, dt, $urandom);
                default: do_load(a, dt, 1'b1, got);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; there SHALL be no other clock or reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clr  input  1  synchronous active-low reset; when 0 at a rising edge, all state returns to reset values.
REQ-004 MEM_MemRead  input  1  load request from the EX/MEM register.
REQ-005 MEM_MemWrite  input  1  store request from the EX/MEM register.
REQ-006 MEM_Datatype  input  2  access size: 00 word, 01 signed half, 10 signed byte, 11 unsigned byte.
REQ-007 MEM_ALUResult  input  32  byte address.
REQ-008 MEM_Data2  input  32  store data; the low bits are used for sub-word stores.
REQ-009 MEM_Branch, MEM_Zero  input  1 each  branch resolution inputs.
REQ-010 MEM_ReadData  output  32  extended load result.
REQ-011 MEM_Valid  output  1  load result valid, one-cycle pulse.
REQ-012 MEM_Stall  output  1  freeze the upstream pipeline registers (drives their Ld low).
REQ-013 PCSrc  output  1  branch taken.
REQ-014 MisalignErr  output  1  registered one-cycle pulse for a misaligned access.

Function
REQ-015 PCSrc SHALL equal MEM_Branch AND MEM_Zero, combinationally, in every state.
REQ-016 The internal memory SHALL be 256 x 32-bit words, little-endian, indexed by MEM_ALUResult[9:2].
- Address bits [31:10] are ignored, so addresses wrap modulo 1 KB.
REQ-017 Misaligned accesses SHALL be defined as follows:
- a word access is misaligned when addr[1:0] != 0;
- a half access is misaligned when addr[0] != 0;
- byte accesses are never misaligned.
REQ-018 A misaligned access SHALL perform no memory read or write and SHALL NOT stall.
- MisalignErr = 1 in the following cycle.
REQ-019 The FSM SHALL have three states: IDLE, RD_WAIT, RD_DONE.
REQ-020 In IDLE, an aligned MemRead SHALL capture the address and Datatype, assert MEM_Stall combinationally in the same cycle, and move to RD_WAIT.
REQ-021 RD_WAIT SHALL hold MEM_Stall = 1 and SHALL move unconditionally to RD_DONE.
REQ-022 RD_DONE SHALL drive MEM_Valid = 1 and MEM_Stall = 0, present MEM_ReadData, and return to IDLE.
- Load latency: request cycle N gives data in cycle N+2.
REQ-023 MEM_ReadData SHALL be formed as follows:
- word: the whole word;
- half: lane addr[1] (0 selects bits 15:0, 1 selects bits 31:16), sign-extended;
- signed byte: lane addr[1:0], sign-extended;
- unsigned byte: lane addr[1:0], zero-extended.
REQ-024 An aligned MemWrite in IDLE SHALL write at the same rising edge with byte enables:
- word: 1111;
- half: 0011 or 1100;
- byte: one-hot on addr[1:0];
- store data replicated across lanes.
REQ-025 A store SHALL take one cycle and SHALL NOT stall.
REQ-026 When MemRead and MemWrite are both 1, the read SHALL take priority and the write SHALL be dropped.
REQ-027 Requests arriving while in RD_WAIT or RD_DONE SHALL be ignored.
- Upstream is held by MEM_Stall, so the request is re-presented in IDLE.
REQ-028 Outside RD_DONE, MEM_ReadData SHALL hold its last value and MEM_Valid SHALL be 0.

Reset
REQ-029 While Clr = 0, the following SHALL hold at each rising edge:
- state = IDLE;
- MEM_ReadData = 0;
- MEM_Valid = 0;
- MisalignErr = 0;
- captured address and Datatype = 0;
- MEM_Stall = 0 (combinational from IDLE with no request).
REQ-030 Reset during RD_WAIT or RD_DONE SHALL abort the load with no Valid pulse.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 No write SHALL occur on a cycle where Clr = 0.

Structure
REQ-033 A shared package SHALL hold:
- the state enum (IDLE, RD_WAIT, RD_DONE);
- the Datatype encodings (DT_WORD, DT_HALF, DT_BYTE, DT_UBYTE);
- MEM_DEPTH = 256.
REQ-034 The RAM SHALL be a sub-module, data_ram: 256 x 32, synchronous read, 4-bit byte-enable write.
REQ-035 Lane select, extension, and the FSM SHALL reside in mem_access_unit.

Verification
REQ-036 Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10 -> MEM_Stall high for 2 cycles, then MEM_Valid = 1 with ReadData = 0xDEADBEEF.
REQ-037 Sub-word loads: with 0x80FF7F01 at 0x20:
- signed byte at 0x21 -> 0x0000007F;
- signed byte at 0x23 -> 0xFFFFFF80;
- unsigned byte at 0x22 -> 0x000000FF;
- signed half at 0x22 -> 0xFFFF80FF.
REQ-038 Byte store: store byte 0xAA at 0x31 over 0x11223344 -> word load returns 0x1122AA44.
REQ-039 Misaligned and wrap-around:
- word load at 0x06 -> MisalignErr pulse, no stall, no Valid;
- store at 0x400 overwrites word 0x000.
REQ-040 Priority, reset, and branch:
- MemRead and MemWrite together at 0x40 -> memory unchanged, load completes;
- Clr = 0 in RD_WAIT -> IDLE with no Valid;
- Branch = 1 and Zero = 1 -> PCSrc = 1 in the same cycle.
